// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    // Sweep FSM: zero the array after reset, then serve the core.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Low bit index of port p in a packed vector of W-bit port fields.
    function automatic int unsigned slice_lo(input int unsigned p, input int unsigned w);
        return p * w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Core-side bus of the register file: write ports, read ports, scoreboard alloc.
interface regfile_mp_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 4,
    parameter int unsigned NWR  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic                 init_busy_o;
    logic [NWR-1:0]       wr_we_i;
    logic [NWR*AW-1:0]    wr_addr_i;
    logic [NWR*XLEN-1:0]  wr_data_i;
    logic [NRD*AW-1:0]    rd_addr_i;
    logic [NRD*XLEN-1:0]  rd_data_o;
    logic [NRD-1:0]       rd_pend_o;
    logic                 alloc_we_i;
    logic [AW-1:0]        alloc_addr_i;

    modport slave (
        output init_busy_o,
        input  wr_we_i, wr_addr_i, wr_data_i,
        input  rd_addr_i,
        output rd_data_o, rd_pend_o,
        input  alloc_we_i, alloc_addr_i
    );

    modport master (
        input  init_busy_o,
        output wr_we_i, wr_addr_i, wr_data_i,
        output rd_addr_i,
        input  rd_data_o, rd_pend_o,
        output alloc_we_i, alloc_addr_i
    );

endinterface

// File: rtl/regfile_wr_arb.sv
// Write-port priority resolver: per-register enable/data and per-read-port bypass.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN = 32,
    parameter  int unsigned NREG = 32,
    parameter  int unsigned NRD  = 4,
    parameter  int unsigned NWR  = 2,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic [NWR-1:0]      wr_we_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NREG-1:0]     reg_we_o,
    output logic [XLEN-1:0]     reg_wdata_o [NREG],
    output logic [NRD-1:0]      byp_hit_o,
    output logic [NRD*XLEN-1:0] byp_data_o
);

    // Array update: later (higher-index) ports overwrite earlier ones; x0 never written.
    always_comb begin
        logic [AW-1:0] wa;
        reg_we_o = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            reg_wdata_o[i] = '0;
        end
        for (int unsigned p = 0; p < NWR; p++) begin
            wa = wr_addr_i[slice_lo(p, AW) +: AW];
            if (wr_we_i[p] && (wa != '0)) begin
                reg_we_o[wa]    = 1'b1;
                reg_wdata_o[wa] = wr_data_i[slice_lo(p, XLEN) +: XLEN];
            end
        end
    end

    // Read bypass: highest-index enabled write port matching the read address.
    always_comb begin
        logic [AW-1:0] ra;
        byp_hit_o  = '0;
        byp_data_o = '0;
        for (int unsigned r = 0; r < NRD; r++) begin
            ra = rd_addr_i[slice_lo(r, AW) +: AW];
            for (int unsigned p = 0; p < NWR; p++) begin
                if (wr_we_i[p] && (ra != '0) && (wr_addr_i[slice_lo(p, AW) +: AW] == ra)) begin
                    byp_hit_o[r]                           = 1'b1;
                    byp_data_o[slice_lo(r, XLEN) +: XLEN] = wr_data_i[slice_lo(p, XLEN) +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with post-reset zero sweep and pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 4,
    parameter int unsigned NWR  = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    rf_state_e           state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                busy_q;
    logic [NREG-1:0]     pend_q, pend_d;
    logic [XLEN-1:0]     regs_q [NREG];

    logic                ready;
    logic [NWR-1:0]      wr_we_gated;
    logic [NREG-1:0]     reg_we;
    logic [XLEN-1:0]     reg_wdata [NREG];
    logic [NRD-1:0]      byp_hit;
    logic [NRD*XLEN-1:0] byp_data;
    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_pend_c;

    assign ready       = (state_q == READY);
    assign wr_we_gated = bus.wr_we_i & {NWR{ready}};

    regfile_wr_arb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)
    ) u_wr_arb (
        .wr_we_i     (wr_we_gated),
        .wr_addr_i   (bus.wr_addr_i),
        .wr_data_i   (bus.wr_data_i),
        .rd_addr_i   (bus.rd_addr_i),
        .reg_we_o    (reg_we),
        .reg_wdata_o (reg_wdata),
        .byp_hit_o   (byp_hit),
        .byp_data_o  (byp_data)
    );

    // Sweep FSM state, counter and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == CLEAR);
        end
    end

    // Sweep FSM next state: walk x1..x(NREG-1), then serve until the next reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    // Array storage: sweep zeroes one register per cycle, then resolved writes land.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[cnt_q] <= '0;
            end else begin
                for (int unsigned i = 1; i < NREG; i++) begin
                    if (reg_we[i]) begin
                        regs_q[i] <= reg_wdata[i];
                    end
                end
            end
        end
    end

    // Scoreboard next state: writes retire a producer, a same-cycle alloc wins.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (reg_we[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        if (bus.alloc_we_i && (bus.alloc_addr_i != '0)) begin
            pend_d[bus.alloc_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard flops; frozen during the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else if (ready) begin
            pend_q <= pend_d;
        end
    end

    // Read muxes: x0 and the sweep read as zero, same-cycle writes bypass the array.
    always_comb begin
        logic [AW-1:0] ra;
        rd_data_c = '0;
        rd_pend_c = '0;
        for (int unsigned r = 0; r < NRD; r++) begin
            ra = bus.rd_addr_i[slice_lo(r, AW) +: AW];
            if (ready && (ra != '0)) begin
                if (byp_hit[r]) begin
                    rd_data_c[slice_lo(r, XLEN) +: XLEN] = byp_data[slice_lo(r, XLEN) +: XLEN];
                end else begin
                    rd_data_c[slice_lo(r, XLEN) +: XLEN] = regs_q[ra];
                    rd_pend_c[r]                         = pend_q[ra];
                end
            end
        end
    end

    assign bus.rd_data_o   = rd_data_c;
    assign bus.rd_pend_o   = rd_pend_c;
    assign bus.init_busy_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed plan plus randomized traffic vs a reference model.
module tb_regfile_mp;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 4;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = $clog2(NREG);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) intf ();

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    // Stimulus for the current cycle
    logic [NWR-1:0]  s_we;
    logic [AW-1:0]   s_wa [NWR];
    logic [XLEN-1:0] s_wd [NWR];
    logic [AW-1:0]   s_ra [NRD];
    logic            s_aw;
    logic [AW-1:0]   s_aa;

    // Reference model: architectural contents, pending flags, sweep cycles left
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_pend [NREG];
    int              m_remain = 0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_we = '0;
        s_aw = 1'b0;
        s_aa = '0;
        for (int p = 0; p < NWR; p++) begin
            s_wa[p] = '0;
            s_wd[p] = '0;
        end
        for (int r = 0; r < NRD; r++) s_ra[r] = AW'(r + 1);
    endtask

    task automatic randomize_inputs(input bit narrow);
        for (int p = 0; p < NWR; p++) begin
            s_we[p] = 1'($urandom_range(0, 1));
            s_wa[p] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
            s_wd[p] = XLEN'($urandom);
        end
        s_aw = 1'($urandom_range(0, 1));
        s_aa = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
        for (int r = 0; r < NRD; r++) begin
            s_ra[r] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
        end
    endtask

    // Drive the bus and let combinational reads settle
    task automatic apply();
        intf.wr_we_i      = s_we;
        intf.alloc_we_i   = s_aw;
        intf.alloc_addr_i = s_aa;
        for (int p = 0; p < NWR; p++) begin
            intf.wr_addr_i[p*AW +: AW]     = s_wa[p];
            intf.wr_data_i[p*XLEN +: XLEN] = s_wd[p];
        end
        for (int r = 0; r < NRD; r++) intf.rd_addr_i[r*AW +: AW] = s_ra[r];
        #1;
    endtask

    function automatic logic [XLEN-1:0] rd_obs(input int r);
        return intf.rd_data_o[r*XLEN +: XLEN];
    endfunction

    // Compare busy and every read port against the model's view of this cycle
    task automatic check_all();
        logic [XLEN-1:0] ed;
        bit              ep;
        bit              hit;
        chk("init_busy", XLEN'(intf.init_busy_o), XLEN'(m_remain > 0));
        for (int r = 0; r < NRD; r++) begin
            ed  = '0;
            ep  = 1'b0;
            hit = 1'b0;
            if (m_remain == 0 && s_ra[r] != '0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (s_we[p] && s_wa[p] == s_ra[r]) begin
                        hit = 1'b1;
                        ed  = s_wd[p];
                    end
                end
                if (!hit) begin
                    ed = m_regs[s_ra[r]];
                    ep = m_pend[s_ra[r]];
                end
            end
            chk($sformatf("rd_data[%0d] x%0d", r, s_ra[r]), rd_obs(r), ed);
            chk($sformatf("rd_pend[%0d] x%0d", r, s_ra[r]), XLEN'(intf.rd_pend_o[r]), XLEN'(ep));
        end
    endtask

    // Clock edge: advance the model by one cycle with the applied inputs
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_remain = NREG - 1;
            for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        end else if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
                for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (s_we[p] && s_wa[p] != '0) begin
                    m_regs[s_wa[p]] = s_wd[p];
                    m_pend[s_wa[p]] = 1'b0;
                end
            end
            if (s_aw && s_aa != '0) m_pend[s_aa] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        apply();
        check_all();
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle();
        apply();
        tick();
        step();
        rst = 1'b0;

        // 1: zero sweep length and contents
        n = 0;
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < NRD; r++) s_ra[r] = AW'($urandom_range(1, NREG - 1));
            apply();
            check_all();
            if (intf.init_busy_o) n++;
            tick();
        end
        chk("sweep_busy_cycles", XLEN'(n), XLEN'(31));
        for (int a = 1; a < NREG; a += NRD) begin
            for (int r = 0; r < NRD; r++) s_ra[r] = AW'((a + r) % NREG);
            apply();
            check_all();
            chk($sformatf("sweep_zero x%0d", s_ra[0]), rd_obs(0), 32'h0);
            tick();
        end

        // 2: dual write to x5, highest port wins, bypass then stored
        idle();
        s_we = 2'b11; s_wa[0] = 5; s_wa[1] = 5;
        s_wd[0] = 32'h1111_1111; s_wd[1] = 32'h2222_2222; s_ra[0] = 5;
        apply(); check_all();
        chk("t2_bypass", rd_obs(0), 32'h2222_2222);
        tick();
        idle(); s_ra[0] = 5;
        apply(); check_all();
        chk("t2_stored", rd_obs(0), 32'h2222_2222);
        tick();

        // 3: x0 protection
        idle();
        s_we[0] = 1'b1; s_wa[0] = 0; s_wd[0] = 32'hDEAD_BEEF;
        s_aw = 1'b1; s_aa = 0; s_ra[0] = 0;
        apply(); check_all();
        chk("t3_data_same", rd_obs(0), 32'h0);
        tick();
        idle(); s_ra[0] = 0;
        apply(); check_all();
        chk("t3_data", rd_obs(0), 32'h0);
        chk("t3_pend", XLEN'(intf.rd_pend_o[0]), 32'h0);
        tick();

        // 4: scoreboard alloc then retiring write
        idle(); s_aw = 1'b1; s_aa = 7; s_ra[0] = 7;
        apply(); check_all();
        chk("t4_alloc_not_bypassed", XLEN'(intf.rd_pend_o[0]), 32'h0);
        tick();
        idle(); s_ra[0] = 7;
        apply(); check_all();
        chk("t4_pend_set", XLEN'(intf.rd_pend_o[0]), 32'h1);
        tick();
        idle(); s_ra[0] = 7; s_we[0] = 1'b1; s_wa[0] = 7; s_wd[0] = 32'hA5A5_A5A5;
        apply(); check_all();
        chk("t4_pend_bypass", XLEN'(intf.rd_pend_o[0]), 32'h0);
        chk("t4_data_bypass", rd_obs(0), 32'hA5A5_A5A5);
        tick();

        // 5: alloc and write collide on x9
        idle(); s_aw = 1'b1; s_aa = 9; s_we[1] = 1'b1; s_wa[1] = 9; s_wd[1] = 32'h0000_1234;
        step();
        idle(); s_ra[0] = 9;
        apply(); check_all();
        chk("t5_pend", XLEN'(intf.rd_pend_o[0]), 32'h1);
        chk("t5_data", rd_obs(0), 32'h0000_1234);
        tick();

        // 6: reset mid-sweep restarts a full sweep; sweep-time writes dropped
        idle(); s_aw = 1'b1; s_aa = 12;
        step();
        rst = 1'b1; idle(); step(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            randomize_inputs(1'b0);
            step();
        end
        rst = 1'b1; idle(); step(); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            randomize_inputs(1'b0);
            if (i >= 31) s_we = '0;
            if (i >= 31) s_aw = 1'b0;
            apply();
            check_all();
            if (intf.init_busy_o) n++;
            tick();
        end
        chk("t6_busy_cycles", XLEN'(n), XLEN'(31));
        idle(); s_ra[0] = 12; s_ra[1] = 5; s_ra[2] = 9; s_ra[3] = 7;
        apply(); check_all();
        chk("t6_pend_x12", XLEN'(intf.rd_pend_o[0]), 32'h0);
        chk("t6_zero_x5", rd_obs(1), 32'h0);
        chk("t6_zero_x9", rd_obs(2), 32'h0);
        tick();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            randomize_inputs(i[0]);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read x0..x31 file.
- Sits between decode/issue (reads, producer allocation) and writeback (multiple retire ports) of a superscalar RV32 core.
- Adds configurable width, depth and port counts, and a deterministic hardware zero-sweep after reset.
- Adds a per-register pending scoreboard, so issue logic can detect RAW hazards without a separate block.

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 32, number of architectural registers; must be a power of 2 and >= 4.
- NRD, 4, number of read ports.
- NWR, 2, number of write ports.
- AW, $clog2(NREG), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- init_busy_o  out  1  high while the zero-sweep runs; the core must stall issue.
- wr_we_i  in  NWR  per-port write enable.
- wr_addr_i  in  NWR*AW  packed write addresses; port p occupies bits [p*AW +: AW].
- wr_data_i  in  NWR*XLEN  packed write data.
- rd_addr_i  in  NRD*AW  packed read addresses.
- rd_data_o  out  NRD*XLEN  packed read data; combinational.
- rd_pend_o  out  NRD  per read port: the addressed register has an outstanding producer.
- alloc_we_i  in  1  mark one register pending (issue of a producing instruction).
- alloc_addr_i  in  AW  register to mark pending.

Behaviour:
- Register 0 reads as 0 and is never pending; writes and allocs to address 0 are ignored.
- Reset: while rst=1, state=CLEAR, sweep counter=1, every pending bit=0, init_busy_o=1.
- FSM CLEAR:
  - Each cycle with rst=0, regs[cnt]<=0 and cnt<=cnt+1.
  - The cycle that writes cnt=NREG-1 transitions to READY.
  - init_busy_o=1 for exactly NREG-1 cycles after rst falls; 0 from the next cycle.
- FSM READY: holds until rst. No other transitions.
- Reset asserted mid-sweep or in READY: the sweep restarts from cnt=1 and all pending bits clear in the same edge.
- During CLEAR:
  - wr_we_i and alloc_we_i are ignored.
  - rd_data_o=0 and rd_pend_o=0 on all ports.
- Write in READY: for each port p with wr_we_i[p]=1 and addr!=0, regs[addr]<=data and pend[addr]<=0.
- Write-write conflict (same addr on several ports, same cycle): the highest-index port wins; the others are dropped silently.
- Alloc in READY: pend[alloc_addr_i]<=1.
  - If a write to the same address occurs in the same cycle, alloc wins (pend ends at 1, data is written).
- Read (combinational, zero latency), per read port r:
  - addr 0 -> data 0, pend 0.
  - Otherwise, if any enabled write port matches addr this cycle -> bypass data from the highest-index matching port, and rd_pend_o=0.
  - Otherwise -> regs[addr] and pend[addr].
- Alloc is not bypassed to reads: a same-cycle alloc is visible on rd_pend_o the next cycle.
- Array contents are not reset directly; only the sweep zeroes them. Pending bits are flops with synchronous reset.

Decomposition:
- Shared package regfile_pkg: FSM state encoding (CLEAR, READY) and a packed-slice helper function for port p of width W.
- Natural sub-module regfile_wr_arb:
  - Priority-resolves NWR write ports into a per-register write enable and data select.
  - Also returns, per read address, the bypass hit and data.
  - Purely combinational.
  - Instanced once for array update; its bypass function is used per read port.
- Top level holds the array, pending vector, sweep FSM/counter and read muxes.

Test Plan:
1. Sweep: rst high 2 cycles then low; array preloaded with X.
   -> init_busy_o=1 for 31 cycles then 0; all 4 read ports return 0x00000000 for addresses 1..31.
2. Dual write plus bypass: after init, port0 writes x5=0x11111111 and port1 writes x5=0x22222222 in the same cycle, with rd_addr[0]=5.
   -> rd_data_o[0]=0x22222222 the same cycle; a read of x5 next cycle =0x22222222.
3. x0 protection: write x0=0xDEADBEEF and alloc x0.
   -> reading x0 gives data 0, pend 0.
4. Scoreboard: alloc x7; next cycle read x7.
   -> rd_pend_o=1. A write of x7=0xA5A5A5A5 then gives pend 0 in the same cycle (bypass) and data 0xA5A5A5A5.
5. Alloc/write collision: alloc x9 and write x9=0x1234 in the same cycle.
   -> next cycle pend=1 and data=0x1234.
6. Reset mid-sweep: assert rst after 10 sweep cycles, then release.
   -> init_busy_o=1 for a full 31 cycles; pending bits are 0; writes issued during the sweep have no effect.
